// File: rtl/clock_divider2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider2_pkg
// Description : Shared defaults and a width helper for the clock_divider2
//               timing block (divided clock, servo PWM, enabled-cycle count).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_divider2_pkg;

    localparam int DIV_DEF        = 10;
    localparam int PWM_PERIOD_DEF = 100;
    localparam int PWM_HIGH_DEF   = 15;
    localparam int CNT_WIDTH_DEF  = 32;

    // Bits needed to hold 0..n-1; never less than one bit so that a
    // modulus of 1 or 2 still yields a legal vector.
    function automatic int cnt_width(input longint unsigned n);
        if (n <= 64'd2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : clock_divider2_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Enabled modulo-MOD up-counter with asynchronous reset.
//   clk   - clock (rising edge)
//   rst   - asynchronous active-high reset, clears count
//   en    - advance enable; count holds while low
//   count - current value, 0..MOD-1 (registered)
//   wrap  - high during the enabled cycle in which count returns to 0
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter longint unsigned MOD = 2,
    parameter int              W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] c_LAST = W'(MOD - 64'd1);

    if (MOD < 64'd1) begin : g_bad_mod
        $error("mod_counter: MOD must be >= 1");
    end
    if (W < 1 || W > 63 || MOD > (64'd1 << W)) begin : g_bad_width
        $error("mod_counter: W too small for MOD");
    end

    logic [W-1:0] r_count;
    logic         w_at_last;

    assign w_at_last = (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + W'(1);
            end
        end
    end

    assign count = r_count;
    assign wrap  = en & w_at_last;

endmodule : mod_counter
`default_nettype wire

// File: rtl/clock_divider2.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider2
// Description : From one input clock produce a 50%-duty divided clock, a
//               fixed-width servo PWM pulse train and an enabled-cycle count.
//   in_clkt   - sole clock, all state changes on its rising edge
//   resett    - asynchronous active-high reset
//   enablet   - count enable; all state freezes while low
//   out_clkt  - divided clock (DIV enabled edges per period), registered
//   servo_pwm - high PWM_HIGH of every PWM_PERIOD enabled edges, registered
//   n_clkst   - enabled edges since reset, modulo 2^CNT_WIDTH, registered
// out_clkt is a plain flop output meant as data/enable downstream, not as
// a clock.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider2
    import clock_divider2_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int PWM_PERIOD = PWM_PERIOD_DEF,
    parameter int PWM_HIGH   = PWM_HIGH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 in_clkt,
    input  logic                 resett,
    input  logic                 enablet,
    output logic                 out_clkt,
    output logic                 servo_pwm,
    output logic [CNT_WIDTH-1:0] n_clkst
);

    localparam int              HALF      = DIV / 2;
    localparam int              c_DIV_W   = cnt_width(64'(HALF));
    localparam int              c_PWM_W   = cnt_width(64'(PWM_PERIOD));
    localparam longint unsigned c_CNT_MOD = 64'd1 << CNT_WIDTH;
    // One extra bit so PWM_HIGH == PWM_PERIOD (a power of two) still fits.
    localparam logic [c_PWM_W:0] c_PWM_HIGH = (c_PWM_W + 1)'(PWM_HIGH);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $error("clock_divider2: DIV must be even and >= 2");
    end
    if (PWM_PERIOD < 1) begin : g_bad_period
        $error("clock_divider2: PWM_PERIOD must be >= 1");
    end
    if (PWM_HIGH < 0 || PWM_HIGH > PWM_PERIOD) begin : g_bad_high
        $error("clock_divider2: PWM_HIGH must be within 0..PWM_PERIOD");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 63) begin : g_bad_cnt_width
        $error("clock_divider2: CNT_WIDTH must be within 1..63");
    end

    logic [c_DIV_W-1:0]   w_div_cnt_unused;
    logic                 w_div_wrap;
    logic [c_PWM_W-1:0]   w_pwm_cnt;
    logic                 w_pwm_wrap_unused;
    logic                 w_cnt_wrap_unused;
    logic                 r_out_clk;
    logic                 r_servo;

    // Half-period counter: each wrap is one out_clkt edge.
    mod_counter #(
        .MOD (64'(HALF)),
        .W   (c_DIV_W)
    ) u_div_cnt (
        .clk   (in_clkt),
        .rst   (resett),
        .en    (enablet),
        .count (w_div_cnt_unused),
        .wrap  (w_div_wrap)
    );

    mod_counter #(
        .MOD (64'(PWM_PERIOD)),
        .W   (c_PWM_W)
    ) u_pwm_cnt (
        .clk   (in_clkt),
        .rst   (resett),
        .en    (enablet),
        .count (w_pwm_cnt),
        .wrap  (w_pwm_wrap_unused)
    );

    // Free-running modulo 2^CNT_WIDTH; wrap-around is silent.
    mod_counter #(
        .MOD (c_CNT_MOD),
        .W   (CNT_WIDTH)
    ) u_edge_cnt (
        .clk   (in_clkt),
        .rst   (resett),
        .en    (enablet),
        .count (n_clkst),
        .wrap  (w_cnt_wrap_unused)
    );

    always_ff @(posedge in_clkt or posedge resett) begin
        if (resett) begin
            r_out_clk <= 1'b0;
        end else if (w_div_wrap) begin
            r_out_clk <= ~r_out_clk;
        end
    end

    // Compare the pre-increment count so the pulse covers enabled edges
    // 1..PWM_HIGH of each period.
    always_ff @(posedge in_clkt or posedge resett) begin
        if (resett) begin
            r_servo <= 1'b0;
        end else if (enablet) begin
            r_servo <= ({1'b0, w_pwm_cnt} < c_PWM_HIGH);
        end
    end

    assign out_clkt  = r_out_clk;
    assign servo_pwm = r_servo;

endmodule : clock_divider2
`default_nettype wire

// File: tb/tb_clock_divider2.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider2
// Description : Directed self-checking bench for clock_divider2. A default
//               instance and a boundary instance (DIV=2, PWM_HIGH=0,
//               CNT_WIDTH=4) share clock, reset and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clock_divider2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        w_out;
    logic        w_servo;
    logic [31:0] w_cnt;
    logic        w_out_b;
    logic        w_servo_b;
    logic [3:0]  w_cnt_b;

    int n_cmp;
    int n_err;

    clock_divider2 u_dut (
        .in_clkt   (clk),
        .resett    (rst),
        .enablet   (en),
        .out_clkt  (w_out),
        .servo_pwm (w_servo),
        .n_clkst   (w_cnt)
    );

    clock_divider2 #(
        .DIV        (2),
        .PWM_PERIOD (100),
        .PWM_HIGH   (0),
        .CNT_WIDTH  (4)
    ) u_bnd (
        .in_clkt   (clk),
        .resett    (rst),
        .enablet   (en),
        .out_clkt  (w_out_b),
        .servo_pwm (w_servo_b),
        .n_clkst   (w_cnt_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called 2 ns after an edge: assert reset mid-cycle, verify the outputs
    // clear before any further edge, release before the next edge.
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #2;
        chk({tag, "_out"},     32'(w_out),     32'd0);
        chk({tag, "_servo"},   32'(w_servo),   32'd0);
        chk({tag, "_cnt"},     w_cnt,          32'd0);
        chk({tag, "_out_b"},   32'(w_out_b),   32'd0);
        chk({tag, "_cnt_b"},   32'(w_cnt_b),   32'd0);
        #2 rst = 1'b0;
    endtask

    int rises_out, high_out, rises_servo, high_servo, toggles_b, high_servo_b;
    logic prev_out, prev_servo, prev_out_b;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b1;

        // Reset held across two edges with enable high.
        step();
        step();
        chk("rst_out",     32'(w_out),     32'd0);
        chk("rst_servo",   32'(w_servo),   32'd0);
        chk("rst_cnt",     w_cnt,          32'd0);
        chk("rst_out_b",   32'(w_out_b),   32'd0);
        chk("rst_servo_b", 32'(w_servo_b), 32'd0);
        chk("rst_cnt_b",   32'(w_cnt_b),   32'd0);
        rst = 1'b0;

        // 400 enabled edges from reset.
        rises_out = 0; high_out = 0; rises_servo = 0; high_servo = 0;
        toggles_b = 0; high_servo_b = 0;
        prev_out = 1'b0; prev_servo = 1'b0; prev_out_b = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (w_out && !prev_out)     rises_out++;
            if (w_out)                  high_out++;
            if (w_servo && !prev_servo) rises_servo++;
            if (w_servo)                high_servo++;
            if (w_out_b != prev_out_b)  toggles_b++;
            if (w_servo_b)              high_servo_b++;
            prev_out = w_out; prev_servo = w_servo; prev_out_b = w_out_b;
            case (k)
                1: begin
                    chk("e1_servo", 32'(w_servo), 32'd1);
                    chk("e1_out_b", 32'(w_out_b), 32'd1);
                end
                2:   chk("e2_out_b",    32'(w_out_b), 32'd0);
                4:   chk("e4_out",      32'(w_out),   32'd0);
                5:   chk("e5_out",      32'(w_out),   32'd1);
                10:  chk("e10_out",     32'(w_out),   32'd0);
                15: begin
                    chk("e15_out",   32'(w_out),   32'd1);
                    chk("e15_servo", 32'(w_servo), 32'd1);
                    chk("e15_cnt_b", 32'(w_cnt_b), 32'd15);
                end
                16: begin
                    chk("e16_servo", 32'(w_servo), 32'd0);
                    chk("e16_cnt_b", 32'(w_cnt_b), 32'd0);
                end
                100: chk("e100_servo", 32'(w_servo), 32'd0);
                101: chk("e101_servo", 32'(w_servo), 32'd1);
                default: ;
            endcase
        end
        chk("e400_cnt",      w_cnt,              32'd400);
        chk("e400_cnt_b",    32'(w_cnt_b),       32'd0);
        chk("out_rises",     32'(rises_out),     32'd40);
        chk("out_high",      32'(high_out),      32'd200);
        chk("servo_pulses",  32'(rises_servo),   32'd4);
        chk("servo_high",    32'(high_servo),    32'd60);
        chk("out_b_toggles", 32'(toggles_b),     32'd400);
        chk("servo_b_high",  32'(high_servo_b),  32'd0);

        // Restart, run to 23, freeze for 7 edges, resume.
        async_reset("rstA");
        for (int k = 1; k <= 23; k++) step();
        chk("g23_cnt",   w_cnt,          32'd23);
        chk("g23_out_b", 32'(w_out_b),   32'd1);
        chk("g23_cnt_b", 32'(w_cnt_b),   32'd7);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("frz_cnt",   w_cnt,          32'd23);
            chk("frz_out",   32'(w_out),     32'd0);
            chk("frz_servo", 32'(w_servo),   32'd0);
            chk("frz_out_b", 32'(w_out_b),   32'd1);
            chk("frz_cnt_b", 32'(w_cnt_b),   32'd7);
        end
        en = 1'b1;
        step();
        chk("r24_cnt",   w_cnt,          32'd24);
        chk("r24_out",   32'(w_out),     32'd0);
        chk("r24_out_b", 32'(w_out_b),   32'd0);
        chk("r24_cnt_b", 32'(w_cnt_b),   32'd8);
        step();
        chk("r25_out",   32'(w_out),     32'd1);
        chk("r25_cnt",   w_cnt,          32'd25);
        for (int k = 26; k <= 137; k++) step();
        chk("m137_cnt",   w_cnt,        32'd137);
        chk("m137_out",   32'(w_out),   32'd1);
        chk("m137_servo", 32'(w_servo), 32'd0);

        // Asynchronous reset mid-run, then the sequence restarts from edge 1.
        async_reset("rstB");
        for (int k = 1; k <= 101; k++) begin
            step();
            case (k)
                1:   chk("p1_servo",   32'(w_servo), 32'd1);
                4:   chk("p4_out",     32'(w_out),   32'd0);
                5:   chk("p5_out",     32'(w_out),   32'd1);
                10:  chk("p10_out",    32'(w_out),   32'd0);
                15:  chk("p15_servo",  32'(w_servo), 32'd1);
                16:  chk("p16_servo",  32'(w_servo), 32'd0);
                101: begin
                    chk("p101_servo", 32'(w_servo), 32'd1);
                    chk("p101_cnt",   w_cnt,        32'd101);
                end
                default: ;
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_clock_divider2
`default_nettype wire
